ras_ckpt_stack: RTL and testbench
=================================

// Module: ras_ckpt_stack
// PURPOSE
//   Parametrised return-address stack for the frontend branch predictor, replacing the fixed
//   push/pop RAS. Adds depth-independent circular wrap, overflow/underflow reporting, and a
//   bank of speculative checkpoints so the stack can be restored on a branch mispredict.
//   Sits beside the BTB/BHT in the frontend. Depth defaults to the core config RASDepth.
// PARAMETERS
//   VLEN      64  width of a stored return address (config XLEN)
//   DEPTH     2   stack entries; any integer >= 2, need not be a power of two
//   NR_CKPT   4   checkpoint slots; >= 1
//   PTR_W     $clog2(DEPTH) (min 1); CNT_W = $clog2(DEPTH+1); CK_W = $clog2(NR_CKPT) (min 1)
// PORTS
//   clk_i         in   1      clock
//   rst_ni        in   1      asynchronous active-low reset
//   flush_i       in   1      empty stack (ptr/count to 0)
//   push_i        in   1      call: push addr_i
//   pop_i         in   1      return: pop top entry
//   addr_i        in   VLEN   return address to push
//   data_o        out  VLEN   current top entry (combinational read of stack[ptr])
//   valid_o       out  1      count != 0
//   occupancy_o   out  CNT_W  current count, 0..DEPTH
//   ckpt_i        in   1      save state into slot ckpt_id_i
//   ckpt_id_i     in   CK_W   checkpoint slot to write
//   restore_i     in   1      restore state from slot restore_id_i
//   restore_id_i  in   CK_W   checkpoint slot to read
//   overflow_o    out  1      1-cycle pulse: push overwrote oldest valid entry
//   underflow_o   out  1      1-cycle pulse: pop while empty
// BEHAVIOUR
//   Reset (async, rst_ni=0): all entries 0, ptr 0, count 0, all checkpoints {ptr 0, count 0,
//     top 0}; data_o=0, valid_o=0, occupancy_o=0, overflow_o=0, underflow_o=0.
//   State: entries[DEPTH], ptr (index of top), count. All updates at posedge; effects visible
//     on data_o/valid_o the cycle after the command (latency 1).
//   Priority (one action per cycle): flush_i > restore_i > push/pop. Lower-priority inputs in
//     the same cycle are ignored; ckpt_i ignored when flush_i or restore_i is high.
//   Wrap: inc(p) = (p==DEPTH-1) ? 0 : p+1; dec(p) = (p==0) ? DEPTH-1 : p-1.
//   push only: ptr<=inc(ptr); entries[inc(ptr)]<=addr_i; count<=min(count+1,DEPTH);
//     overflow_o=1 next cycle iff count==DEPTH before push.
//   pop only: count!=0 -> ptr<=dec(ptr), count<=count-1; count==0 -> no state change,
//     underflow_o=1 next cycle.
//   push+pop same cycle: entries[ptr]<=addr_i, ptr/count unchanged (count==0 -> acts as
//     plain push, count becomes 1, no underflow).
//   flush: ptr<=0, count<=0; entries and checkpoints untouched.
//   ckpt_i: slot[ckpt_id_i] <= {ptr, count, entries[ptr]} sampled BEFORE any same-cycle
//     push/pop (pre-update state); push/pop still executes that cycle.
//   restore_i: ptr<=slot.ptr, count<=slot.count, entries[slot.ptr]<=slot.top. Other
//     entries not rewritten (entries overwritten by >1 push since ckpt are not recovered).
//   overflow_o/underflow_o are registered pulses, cleared every cycle they are not set.
//   Out-of-range ckpt_id_i/restore_id_i (NR_CKPT not power of two): command ignored.
//   Assertions: DEPTH>=2, NR_CKPT>=1, occupancy_o<=DEPTH, never !valid_o with count!=0.
// TESTING
//   Reset mid-operation: 3 pushes then rst_ni=0 async -> valid_o=0, occupancy_o=0 same cycle.
//   DEPTH=3: push A,B,C,D -> overflow_o pulses once after D; pops give D,C,B; 4th pop
//     -> underflow_o=1, valid_o=0.
//   push+pop same cycle with top=0x1000, addr_i=0x2000 -> data_o=0x2000, occupancy unchanged.
//   push 0x10,0x20; ckpt slot1; pop; push 0x30 -> restore slot1 -> data_o=0x20, occupancy 2.
//   flush_i, restore_i and push_i same cycle -> occupancy_o=0, no overflow, slot untouched.
//   DEPTH=5 (non-pow2): 12 pushes -> ptr wraps correctly, pops return last 5 in LIFO order.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack
//   Return-address stack for the frontend predictor. It is a circular buffer of
//   DEPTH entries with wrap at any DEPTH, overflow/underflow pulses, and NR_CKPT
//   speculative checkpoints. A checkpoint stores {ptr, count, top entry} so the
//   stack can be rolled back when a branch mispredicts.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                empty the stack (ptr/count to 0)
//   push_i, pop_i, addr_i  call / return; push and pop together replace the top
//   data_o                 top entry (combinational read of entries[ptr])
//   valid_o, occupancy_o   count != 0, current count
//   ckpt_i, ckpt_id_i      snapshot the pre-update state into a slot
//   restore_i, restore_id_i  reload ptr/count/top from a slot
//   overflow_o/underflow_o registered one-cycle pulses
module ras_ckpt_stack #(
  parameter int unsigned VLEN    = 64,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NR_CKPT = 4,
  parameter int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1),
  parameter int unsigned CK_W    = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  addr_i,
  output logic [VLEN-1:0]  data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] occupancy_o,
  input  logic             ckpt_i,
  input  logic [CK_W-1:0]  ckpt_id_i,
  input  logic             restore_i,
  input  logic [CK_W-1:0]  restore_id_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  typedef struct packed {
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [VLEN-1:0]  top;
  } ckpt_t;

  logic [DEPTH-1:0][VLEN-1:0] entries;
  ckpt_t [NR_CKPT-1:0]        slot;
  logic [PTR_W-1:0]           ptr, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]           cnt;
  logic                       full, empty;
  logic                       restore_ok, ckpt_ok;
  ckpt_t                      rs_slot;

  // Explicit wrap compare so a non-power-of-two DEPTH never indexes past the end.
  assign ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_dec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);

  // Slot ids past NR_CKPT (non-power-of-two bank) are dropped. An ignored
  // restore does not block a push/pop in the same cycle.
  assign restore_ok = restore_i && (32'(restore_id_i) < NR_CKPT);
  assign ckpt_ok    = ckpt_i && !flush_i && !restore_i && (32'(ckpt_id_i) < NR_CKPT);
  assign rs_slot    = restore_ok ? slot[restore_id_i] : '0;

  assign data_o      = entries[ptr];
  assign valid_o     = !empty;
  assign occupancy_o = cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries     <= '0;
      slot        <= '0;
      ptr         <= '0;
      cnt         <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      if (flush_i) begin
        ptr <= '0;
        cnt <= '0;
      end else if (restore_ok) begin
        // Only the top entry is recovered; deeper entries clobbered since the
        // snapshot stay clobbered.
        ptr                   <= rs_slot.ptr;
        cnt                   <= rs_slot.cnt;
        entries[rs_slot.ptr]  <= rs_slot.top;
      end else if (push_i && pop_i && !empty) begin
        entries[ptr] <= addr_i;
      end else if (push_i) begin
        // Also covers push+pop on an empty stack (acts as a plain push).
        ptr              <= ptr_inc;
        entries[ptr_inc] <= addr_i;
        if (full) overflow_o <= 1'b1;
        else      cnt        <= cnt + CNT_W'(1);
      end else if (pop_i) begin
        if (empty) begin
          underflow_o <= 1'b1;
        end else begin
          ptr <= ptr_dec;
          cnt <= cnt - CNT_W'(1);
        end
      end
      // Snapshot uses the pre-update values of this cycle.
      if (ckpt_ok) slot[ckpt_id_i] <= {ptr, cnt, entries[ptr]};
    end
  end

  if (DEPTH < 2) begin : g_bad_depth
    $error("ras_ckpt_stack: DEPTH must be >= 2");
  end
  if (NR_CKPT < 1) begin : g_bad_ckpt
    $error("ras_ckpt_stack: NR_CKPT must be >= 1");
  end

  a_occ_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occupancy_o <= CNT_W'(DEPTH));
  a_valid_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt != '0) |-> valid_o);

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Bench for ras_ckpt_stack with DEPTH=5 and NR_CKPT=3, so that slot id 3 is out
// of range. Each driven cycle pushes the expected post-edge outputs, taken from a
// reference stack model, into a queue. The queue is popped and compared 1ns
// after the edge.
module tb_ras_ckpt_stack;
  localparam int VLEN = 32, DEPTH = 5, NCK = 3;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            flush = 0, push = 0, pop = 0, ckpt = 0, restore = 0;
  logic [VLEN-1:0] addr = '0;
  logic [1:0]      ckpt_id = '0, restore_id = '0;
  logic [VLEN-1:0] data;
  logic            valid, ovf, unf;
  logic [2:0]      occ;

  ras_ckpt_stack #(.VLEN(VLEN), .DEPTH(DEPTH), .NR_CKPT(NCK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
    .addr_i(addr), .data_o(data), .valid_o(valid), .occupancy_o(occ),
    .ckpt_i(ckpt), .ckpt_id_i(ckpt_id), .restore_i(restore), .restore_id_i(restore_id),
    .overflow_o(ovf), .underflow_o(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VLEN-1:0] d;
    bit v;
    int occ;
    bit ovf;
    bit unf;
  } exp_t;
  exp_t sbq[$];

  int n_run = 0, n_fail = 0;
  string cur = "reset";

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", cur, tag, got, exp);
    end
  endtask

  // Reference model
  logic [VLEN-1:0] m_ent[DEPTH];
  int              m_ptr, m_cnt;
  int              ck_ptr[NCK], ck_cnt[NCK];
  logic [VLEN-1:0] ck_top[NCK];

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    for (int i = 0; i < NCK; i++) begin ck_ptr[i] = 0; ck_cnt[i] = 0; ck_top[i] = '0; end
    m_ptr = 0; m_cnt = 0;
  endtask

  task automatic step(input bit f, input bit ps, input bit pp, input logic [VLEN-1:0] a,
                      input bit ck, input int ckid, input bit rs, input int rsid);
    int p0, c0;
    logic [VLEN-1:0] t0;
    exp_t e, g;
    flush = f; push = ps; pop = pp; addr = a;
    ckpt = ck; ckpt_id = 2'(ckid); restore = rs; restore_id = 2'(rsid);
    p0 = m_ptr; c0 = m_cnt; t0 = m_ent[m_ptr];
    e.ovf = 0; e.unf = 0;
    if (f) begin
      m_ptr = 0; m_cnt = 0;
    end else if (rs && rsid < NCK) begin
      m_ptr = ck_ptr[rsid]; m_cnt = ck_cnt[rsid]; m_ent[m_ptr] = ck_top[rsid];
    end else if (ps && pp && m_cnt != 0) begin
      m_ent[m_ptr] = a;
    end else if (ps) begin
      e.ovf = (m_cnt == DEPTH);
      m_ptr = (m_ptr + 1) % DEPTH;
      m_ent[m_ptr] = a;
      if (m_cnt < DEPTH) m_cnt++;
    end else if (pp) begin
      if (m_cnt == 0) e.unf = 1;
      else begin m_ptr = (m_ptr + DEPTH - 1) % DEPTH; m_cnt--; end
    end
    if (ck && !f && !rs && ckid < NCK) begin
      ck_ptr[ckid] = p0; ck_cnt[ckid] = c0; ck_top[ckid] = t0;
    end
    e.d = m_ent[m_ptr]; e.v = (m_cnt != 0); e.occ = m_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("data", 64'(data), 64'(g.d));
    chk("valid", 64'(valid), 64'(g.v));
    chk("occ", 64'(occ), 64'(g.occ));
    chk("ovf", 64'(ovf), 64'(g.ovf));
    chk("unf", 64'(unf), 64'(g.unf));
    flush = 0; push = 0; pop = 0; ckpt = 0; restore = 0;
  endtask

  task automatic do_push(input logic [VLEN-1:0] a); step(0, 1, 0, a, 0, 0, 0, 0); endtask
  task automatic do_pop();                          step(0, 0, 1, '0, 0, 0, 0, 0); endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 64'(data), 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_occ", 64'(occ), 0);
    chk("rst_ovf", 64'(ovf), 0);
    chk("rst_unf", 64'(unf), 0);
    #2 rst_n = 1'b1;

    // The async reset lands mid-cycle and must clear the stack immediately.
    cur = "async_rst";
    do_push(32'h11); do_push(32'h22); do_push(32'h33);
    #3 rst_n = 1'b0;
    #1;
    chk("valid", 64'(valid), 0);
    chk("occ", 64'(occ), 0);
    chk("data", 64'(data), 0);
    m_reset();
    #2 rst_n = 1'b1;

    // Overflow on the sixth push, LIFO pops, then underflow.
    cur = "overflow";
    for (int i = 0; i < 6; i++) do_push(32'hA0 + 32'(i));
    chk("ovf_pulse", 64'(ovf), 1);
    chk("top_after_ovf", 64'(data), 64'h00A5);
    do_pop();
    chk("ovf_cleared", 64'(ovf), 0);
    chk("top_after_pop1", 64'(data), 64'h00A4);
    for (int i = 0; i < 4; i++) do_pop();
    cur = "underflow";
    do_pop();
    chk("unf_pulse", 64'(unf), 1);
    chk("valid_empty", 64'(valid), 0);

    // A push and pop in the same cycle replace the top entry.
    cur = "push_pop";
    do_push(32'h1000);
    step(0, 1, 1, 32'h2000, 0, 0, 0, 0);
    chk("pp_data", 64'(data), 64'h2000);
    chk("pp_occ", 64'(occ), 1);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h3000, 0, 0, 0, 0);
    chk("pp_empty_occ", 64'(occ), 1);

    // A checkpoint taken and then restored across a pop and a push.
    cur = "ckpt";
    step(1, 0, 0, '0, 0, 0, 0, 0);
    do_push(32'h10); do_push(32'h20);
    step(0, 0, 0, '0, 1, 1, 0, 0);
    do_pop();
    do_push(32'h30);
    step(0, 0, 0, '0, 0, 0, 1, 1);
    chk("rs_data", 64'(data), 64'h20);
    chk("rs_occ", 64'(occ), 2);

    // Flush wins over restore, push and ckpt in the same cycle.
    cur = "prio";
    step(1, 1, 0, 32'h99, 1, 1, 1, 1);
    chk("prio_occ", 64'(occ), 0);
    chk("prio_ovf", 64'(ovf), 0);
    step(0, 0, 0, '0, 0, 0, 1, 1);
    chk("slot_kept", 64'(data), 64'h20);

    // A checkpoint taken in the same cycle as a push captures the pre-push state.
    cur = "ckpt_push";
    step(0, 1, 0, 32'h44, 1, 0, 0, 0);
    do_push(32'h55);
    step(0, 0, 0, '0, 0, 0, 1, 0);
    chk("pre_state_occ", 64'(occ), 2);
    step(0, 0, 0, '0, 1, 3, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1, 3);

    // Twelve pushes wrap the non-power-of-two pointer.
    cur = "wrap";
    step(1, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) do_push(32'hC00 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      chk("lifo", 64'(data), 64'(32'hC0B - 32'(i)));
      do_pop();
    end
    chk("wrap_empty", 64'(valid), 0);

    cur = "random";
    for (int i = 0; i < 200; i++)
      step(($urandom % 16) == 0, $urandom % 2, $urandom % 2, $urandom,
           ($urandom % 4) == 0, $urandom % 4, ($urandom % 8) == 0, $urandom % 4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
